// File: rtl/register.sv
`default_nettype none
// ============================================================================
//  Module   : register
//  Brief    : Parameterised '573-style data register: transparent while LE is
//             high, clocked hold while LE is low, tri-state output via OE_n.
//  Revision : 1.0  initial release
// ============================================================================
module register #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic             LE,
  input  logic             OE_n,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= RESET_VALUE;
    end else if (LE) begin
      r_hold <= A;
    end
  end

  // Reset overrides the transparent path too, so the bus never shows A while held in reset.
  always_comb begin
    w_data = RESET_VALUE;
    if (rst_n) begin
      w_data = LE ? A : r_hold;
    end
  end

  assign Q = OE_n ? {WIDTH{1'bz}} : w_data;

endmodule
`default_nettype wire

// File: tb/tb_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register
//  Brief    : Directed vector bench for register; two instances share inputs,
//             one on a pulled-up bus and one on a pulled-down bus, so a floating
//             output reads as all-ones on the first and all-zeros on the second.
//  Revision : 1.0  initial release
// ============================================================================
module tb_register;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic         le;
  logic         oe_n;
  wire  [W-1:0] w_q_pu;
  wire  [W-1:0] w_q_pd;

  int n_tests;
  int n_fail;

  pullup   pu0 (w_q_pu);
  pulldown pd0 (w_q_pd);

  register #(.WIDTH(W)) u_dut_pu (
    .clk(clk), .rst_n(rst_n), .A(a), .LE(le), .OE_n(oe_n), .Q(w_q_pu)
  );

  register #(.WIDTH(W)) u_dut_pd (
    .clk(clk), .rst_n(rst_n), .A(a), .LE(le), .OE_n(oe_n), .Q(w_q_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst_n;
    logic         le;
    logic         oe_n;
    logic [W-1:0] a;
    logic         exp_z;
    logic [W-1:0] exp_q;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic check(input string name, input logic exp_z, input logic [W-1:0] exp_q);
    logic ok;
    n_tests++;
    if (exp_z) ok = (w_q_pu === {W{1'b1}}) && (w_q_pd === {W{1'b0}});
    else       ok = (w_q_pu === exp_q) && (w_q_pd === exp_q);
    if (!ok) begin
      n_fail++;
      if (exp_z)
        $display("FAIL %s: bus(pullup)=%h bus(pulldown)=%h, required high-Z", name, w_q_pu, w_q_pd);
      else
        $display("FAIL %s: bus(pullup)=%h bus(pulldown)=%h, required %h", name, w_q_pu, w_q_pd, exp_q);
    end
  endtask

  task automatic set_vec(input int i, input string name, input logic r, input logic l,
                         input logic o, input logic [W-1:0] d, input logic z,
                         input logic [W-1:0] q);
    vecs[i].name  = name;
    vecs[i].rst_n = r;
    vecs[i].le    = l;
    vecs[i].oe_n  = o;
    vecs[i].a     = d;
    vecs[i].exp_z = z;
    vecs[i].exp_q = q;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    le      = 1'b0;
    oe_n    = 1'b0;
    a       = '0;

    //          name              rst le oe  A             z     expected
    set_vec( 0, "reset_q",        0,  0, 0, 32'h00000000, 1'b0, 32'h00000000);
    set_vec( 1, "release_oe_off", 1,  0, 1, 32'h00000000, 1'b1, 32'h00000000);
    set_vec( 2, "load_12345678",  1,  1, 0, 32'h12345678, 1'b0, 32'h12345678);
    set_vec( 3, "hold_le0",       1,  0, 0, 32'h12345678, 1'b0, 32'h12345678);
    set_vec( 4, "a_chg_in_hold",  1,  0, 0, 32'hAAAAAAAA, 1'b0, 32'h12345678);
    set_vec( 5, "le1_aaaa",       1,  1, 0, 32'hAAAAAAAA, 1'b0, 32'hAAAAAAAA);
    set_vec( 6, "oe_off",         1,  1, 1, 32'hAAAAAAAA, 1'b1, 32'h00000000);
    set_vec( 7, "oe_on",          1,  1, 0, 32'hAAAAAAAA, 1'b0, 32'hAAAAAAAA);
    set_vec( 8, "transp_1111",    1,  1, 0, 32'h11111111, 1'b0, 32'h11111111);
    set_vec( 9, "transp_2222",    1,  1, 0, 32'h22222222, 1'b0, 32'h22222222);
    set_vec(10, "transp_0000",    1,  1, 0, 32'h00000000, 1'b0, 32'h00000000);
    set_vec(11, "transp_ffff",    1,  1, 0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF);
    set_vec(12, "load_disabled",  1,  1, 1, 32'h87654321, 1'b1, 32'h00000000);
    set_vec(13, "enable_8765",    1,  1, 0, 32'h87654321, 1'b0, 32'h87654321);
    set_vec(14, "load_5555",      1,  1, 0, 32'h55555555, 1'b0, 32'h55555555);
    set_vec(15, "le_fall_a_chg",  1,  0, 0, 32'h99999999, 1'b0, 32'h55555555);
    set_vec(16, "le1_9999",       1,  1, 0, 32'h99999999, 1'b0, 32'h99999999);
    set_vec(17, "hold_9999",      1,  0, 0, 32'h99999999, 1'b0, 32'h99999999);
    set_vec(18, "rst_mid_hold",   0,  0, 0, 32'h99999999, 1'b0, 32'h00000000);
    set_vec(19, "after_rst_lost", 1,  0, 0, 32'h99999999, 1'b0, 32'h00000000);
    set_vec(20, "cap_while_off",  1,  1, 1, 32'h0BADF00D, 1'b1, 32'h00000000);
    set_vec(21, "hold_while_off", 1,  0, 1, 32'h13572468, 1'b1, 32'h00000000);
    set_vec(22, "reveal_capture", 1,  0, 0, 32'h13572468, 1'b0, 32'h0BADF00D);

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      rst_n = vecs[i].rst_n;
      le    = vecs[i].le;
      oe_n  = vecs[i].oe_n;
      a     = vecs[i].a;
      #50;
      check(vecs[i].name, vecs[i].exp_z, vecs[i].exp_q);
    end

    // LE pulse that spans no rising edge: shows A transparently but captures nothing.
    @(posedge clk);
    #1;
    le = 1'b1;
    a  = 32'hDEADBEEF;
    #2;
    check("short_le_transp", 1'b0, 32'hDEADBEEF);
    le = 1'b0;
    #1;
    check("short_le_nocap", 1'b0, 32'h0BADF00D);

    // Asynchronous reset between clock edges clears the hold immediately.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 1'b0, 32'h00000000);

    // Reset held while LE is high: output stays at reset value despite A.
    le = 1'b1;
    a  = 32'hCAFE0001;
    #20;
    check("rst_overrides_le", 1'b0, 32'h00000000);

    // Release reset with LE high; first rising edge captures A, then LE drops.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_transp", 1'b0, 32'hCAFE0001);
    @(negedge clk);
    le = 1'b0;
    a  = 32'h00C0FFEE;
    #1;
    check("first_edge_capture", 1'b0, 32'hCAFE0001);
    #30;
    check("hold_after_release", 1'b0, 32'hCAFE0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion before 100000 ns");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/register.md
Name: register

Overview:
- Parameterised-width data register with output enable, modelled on a '573-style octal latch, for the Baby datapath (accumulator, CI, PI staging).
- While LE is high the output follows A with no clock delay. The value is also captured on every clock edge.
- While LE is low the last captured value is held.
- Output drives the shared bus only when OE_n is low, otherwise high-Z.

Parameters:
- WIDTH, 32, data width in bits.
- RESET_VALUE, 0 (WIDTH bits), value loaded into the hold register on reset.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous reset, active low.
- A  input  WIDTH  data in.
- LE  input  1  latch enable, active high: 1 = transparent/load, 0 = hold.
- OE_n  input  1  output enable, active low.
- Q  output  WIDTH  tri-state data out.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Hold register (WIDTH bits):
  - rst_n low → immediately set to RESET_VALUE, independent of clk.
  - Held at RESET_VALUE while rst_n stays low.
- Capture: on rising clk with rst_n high and LE=1, hold register ← A. With LE=0 it is unchanged.
- Internal data:
  - rst_n low → RESET_VALUE, whatever LE is.
  - Else LE=1 → A, combinational and transparent, with zero-cycle latency.
  - Else LE=0 → hold register.
- Output:
  - OE_n=0 → Q = internal data.
  - OE_n=1 → Q = all bits 'z'; every bit floats, no partial drive.
- OE_n only gates the output. It never affects capture: loading with OE_n=1 is legal, and the value appears when OE_n goes low.
- LE falling edge: the held value is the A sampled at the last rising clk while LE=1.
  - A that changes in the same instant as LE falls is not captured.
  - A bench must keep A stable for ≥1 rising clk edge while LE=1 before dropping LE.
- A changes while LE=0: no effect on Q or on the hold register.
- LE=1 continuously: Q tracks every change of A combinationally. The hold register follows on each clk edge.
- Reset released while LE=1: the first rising clk captures A.
- Reset asserted mid-hold: the held value is lost, and Q (if enabled) shows RESET_VALUE.
- Settling: Q settles within 50 ns of any input change when clk period ≤ 20 ns.
- No X propagation from an undriven Q: Q is 'z' only when OE_n=1.

Test Plan (clk = 10 ns period; check 50 ns after each step):
1. rst_n=0, LE=0, OE_n=0 → Q=0x00000000. Then rst_n=1, OE_n=1 → Q=32'hzzzzzzzz.
2. A=0x12345678, LE=1, OE_n=0 → Q=0x12345678. Then LE=0 → Q=0x12345678. Then A=0xAAAAAAAA → Q still 0x12345678. Then LE=1 → Q=0xAAAAAAAA.
3. OE_n=1 → Q all 'z'. Then OE_n=0 → Q=0xAAAAAAAA.
4. Transparent mode, LE=1: A=0x11111111 → Q=0x11111111. Then A=0x22222222 → 0x22222222. Then 0x00000000 → 0x00000000. Then 0xFFFFFFFF → 0xFFFFFFFF.
5. Load while disabled: A=0x87654321, LE=1, OE_n=1 → Q all 'z'. Then OE_n=0 → Q=0x87654321.
6. Hold cycles: A=0x55555555, LE=1 → Q=0x55555555. Then simultaneously LE=0, A=0x99999999 → Q=0x55555555. Then LE=1 → Q=0x99999999. Then LE=0, rst_n pulse low → Q=0x00000000.
